locked_reg_bank: RTL and testbench
==================================

LOCKED_REG_BANK -- requirements
Module: locked_reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of each data register.
REQ-002 SHALL have parameter NUM_REGS, default 4: register count, 2..16.
REQ-003 SHALL have parameter ADDR_W, default 2: address width, with NUM_REGS <= 2**ADDR_W.
REQ-004 SHALL have parameter CNT_W, default 8: violation counter width.
REQ-005 SHALL have parameter DBG_TIMEOUT, default 64: debug window length in cycles, >= 1.
REQ-006 SHALL have port Clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port write, input, 1: write request.
REQ-009 SHALL have port wr_addr, input, ADDR_W: write target.
REQ-010 SHALL have port Data_in, input, DATA_W: write data.
REQ-011 SHALL have port Lock, input, 1: lock request.
REQ-012 SHALL have port lock_addr, input, ADDR_W: lock target.
REQ-013 SHALL have port debug_unlocked, input, 1: debug override request.
REQ-014 SHALL have port rd_addr, input, ADDR_W: read select.
REQ-015 SHALL have port Data_out, output, DATA_W: registered read data.
REQ-016 SHALL have port lock_status, output, NUM_REGS: per-register lock bits.
REQ-017 SHALL have port viol_pulse, output, 1: one-cycle flag for a rejected write.
REQ-018 SHALL have port viol_cnt, output, CNT_W: saturating count of rejected writes.
REQ-019 SHALL have port dbg_open, output, 1: debug window active.

Function
REQ-020 Lock with lock_addr < NUM_REGS SHALL set lock_status[lock_addr] at the next edge.
- Lock bits are sticky until reset.
- Lock with an out-of-range lock_addr SHALL be ignored.
REQ-021 A write SHALL be accepted when all of the following hold:
- wr_addr < NUM_REGS;
- the target lock bit is 0, or dbg_open=1;
- no same-cycle Lock to the same address.
An accepted write updates the register at the next edge.
REQ-022 A write with Lock to the same address in the same cycle SHALL be rejected, and the lock SHALL be set.
REQ-023 A rejected write SHALL leave the register unchanged, assert viol_pulse for exactly the next cycle, and increment viol_cnt.
- viol_cnt saturates at 2**CNT_W-1.
REQ-024 A write to an out-of-range address SHALL be rejected and counted as a violation.
REQ-025 Data_out SHALL equal the register at rd_addr registered one cycle later.
- An out-of-range rd_addr returns 0.
- Data_out returns the old contents when the read coincides with a write to the same address.
REQ-026 The debug FSM SHALL have states IDLE, OPEN and EXPIRED.
- dbg_open=1 only in OPEN.
REQ-027 IDLE->OPEN on a rising edge of debug_unlocked, detected against its previous-cycle sample; the timer loads DBG_TIMEOUT.
REQ-028 In OPEN the timer SHALL decrement each cycle.
- OPEN->EXPIRED when the timer reaches 0 with debug_unlocked still high.
- OPEN->IDLE on debug_unlocked low.
REQ-029 EXPIRED->IDLE only when debug_unlocked=0.
- A held-high debug_unlocked SHALL never reopen the window.
REQ-030 A write in the cycle OPEN exits SHALL be evaluated with dbg_open=1.
- The first cycle in EXPIRED or IDLE SHALL be evaluated with dbg_open=0.

Reset
REQ-031 On resetn=0, asynchronously and regardless of the clock:
- all data registers, lock_status, Data_out, viol_cnt, viol_pulse and dbg_open SHALL be 0;
- the FSM SHALL be IDLE;
- the timer and the debug_unlocked history bit SHALL be 0.
REQ-032 A reset asserted mid debug window SHALL close the window.
- After release, a still-high debug_unlocked SHALL NOT open the window until it falls and rises again.

Configuration
REQ-033 The debug override SHALL exist only when macro LOCKED_REG_BANK_DEBUG_EN is defined.
REQ-034 Without LOCKED_REG_BANK_DEBUG_EN:
- debug_unlocked is ignored;
- the FSM and timer are absent;
- dbg_open is tied to 0;
- locked registers are unconditionally write-protected.

Verification
REQ-035 Reset, then Data_in=16'hA5A5 with write to address 1 -> Data_out=16'hA5A5 one cycle after rd_addr=1; viol_cnt=0.
REQ-036 Lock address 1, then write 16'h1234 to address 1 -> register keeps 16'hA5A5; viol_pulse for one cycle; viol_cnt=1.
REQ-037 Write and Lock to address 2 in the same cycle -> write rejected, lock_status[2]=1, viol_cnt increments.
REQ-038 With the macro defined, DBG_TIMEOUT=4, debug_unlocked rising with address 1 locked:
- a write 2 cycles later succeeds;
- a write 6 cycles later is rejected;
- dbg_open=0 while debug_unlocked stays high.
REQ-039 Drive 260 rejected writes with CNT_W=8 -> viol_cnt holds 255.
REQ-040 Pulse resetn low during OPEN with debug_unlocked held high -> all outputs 0; dbg_open stays 0 until debug_unlocked toggles low then high.

Source files
------------

// File: rtl/locked_reg_bank.sv
// Register bank with sticky per-register write locks, rejected-write reporting and an
// optional timed debug override window, built only when LOCKED_REG_BANK_DEBUG_EN is defined.
module locked_reg_bank #(
    parameter int DATA_W      = 16,
    parameter int NUM_REGS    = 4,
    parameter int ADDR_W      = 2,
    parameter int CNT_W       = 8,
    parameter int DBG_TIMEOUT = 64
) (
    input  logic                Clk,
    input  logic                resetn,
    input  logic                write,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   Data_in,
    input  logic                Lock,
    input  logic [ADDR_W-1:0]   lock_addr,
    input  logic                debug_unlocked,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   Data_out,
    output logic [NUM_REGS-1:0] lock_status,
    output logic                viol_pulse,
    output logic [CNT_W-1:0]    viol_cnt,
    output logic                dbg_open
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] lock_q, lock_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                viol_q, viol_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                dbg_open_q;

    logic                wr_in_range;
    logic                wr_locked;
    logic                same_cycle_lock;
    logic                wr_accept;
    logic                wr_reject;
    logic [DATA_W-1:0]   rd_data;

    // Address decode by match keeps out-of-range addresses from indexing past the bank.
    always_comb begin
        wr_in_range = 1'b0;
        wr_locked   = 1'b0;
        rd_data     = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
                wr_in_range = 1'b1;
                wr_locked   = lock_q[i];
            end
            if (rd_addr == ADDR_W'(i)) begin
                rd_data = regs_q[i];
            end
        end
    end

    assign same_cycle_lock = Lock && (lock_addr == wr_addr);
    assign wr_accept       = write && wr_in_range && (!wr_locked || dbg_open_q) && !same_cycle_lock;
    assign wr_reject       = write && !wr_accept;

    always_comb begin
        regs_d = regs_q;
        lock_d = lock_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_accept && (wr_addr == ADDR_W'(i))) begin
                regs_d[i] = Data_in;
            end
            if (Lock && (lock_addr == ADDR_W'(i))) begin
                lock_d[i] = 1'b1;
            end
        end
        dout_d = rd_data;
        viol_d = wr_reject;
        cnt_d  = cnt_q;
        if (wr_reject && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            lock_q <= '0;
            dout_q <= '0;
            viol_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            lock_q <= lock_d;
            dout_q <= dout_d;
            viol_q <= viol_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef LOCKED_REG_BANK_DEBUG_EN
    // state   | meaning
    // IDLE    | window closed, waiting for a debug_unlocked rising edge
    // OPEN    | window open, timer counting down, locked registers writable
    // EXPIRED | window timed out, waiting for debug_unlocked to drop
    typedef enum logic [1:0] {
        DBG_IDLE    = 2'd0,
        DBG_OPEN    = 2'd1,
        DBG_EXPIRED = 2'd2
    } dbg_state_e;

    localparam int TMR_W = $clog2(DBG_TIMEOUT + 1);

    dbg_state_e       dbg_state_q;
    logic [TMR_W-1:0] dbg_tmr_q;
    logic             dbg_prev_q;
    logic             dbg_seen_low_q;
    logic             dbg_rise;

    // After reset a rise only counts once debug_unlocked has been seen low.
    assign dbg_rise = debug_unlocked && !dbg_prev_q && dbg_seen_low_q;

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            dbg_state_q    <= DBG_IDLE;
            dbg_tmr_q      <= '0;
            dbg_prev_q     <= 1'b0;
            dbg_seen_low_q <= 1'b0;
            dbg_open_q     <= 1'b0;
        end else begin
            dbg_prev_q <= debug_unlocked;
            if (!debug_unlocked) begin
                dbg_seen_low_q <= 1'b1;
            end
            case (dbg_state_q)
                DBG_IDLE: begin
                    if (dbg_rise) begin
                        dbg_state_q <= DBG_OPEN;
                        dbg_tmr_q   <= TMR_W'(DBG_TIMEOUT);
                        dbg_open_q  <= 1'b1;
                    end
                end
                DBG_OPEN: begin
                    if (!debug_unlocked) begin
                        dbg_state_q <= DBG_IDLE;
                        dbg_tmr_q   <= '0;
                        dbg_open_q  <= 1'b0;
                    end else if (dbg_tmr_q <= TMR_W'(1)) begin
                        dbg_state_q <= DBG_EXPIRED;
                        dbg_tmr_q   <= '0;
                        dbg_open_q  <= 1'b0;
                    end else begin
                        dbg_tmr_q <= dbg_tmr_q - TMR_W'(1);
                    end
                end
                DBG_EXPIRED: begin
                    if (!debug_unlocked) begin
                        dbg_state_q <= DBG_IDLE;
                    end
                end
                default: begin
                    dbg_state_q <= DBG_IDLE;
                    dbg_tmr_q   <= '0;
                    dbg_open_q  <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_debug_unlocked;
    assign unused_debug_unlocked = debug_unlocked;
    assign dbg_open_q            = 1'b0;
`endif

    assign Data_out    = dout_q;
    assign lock_status = lock_q;
    assign viol_pulse  = viol_q;
    assign viol_cnt    = cnt_q;
    assign dbg_open    = dbg_open_q;

endmodule

// File: tb/tb_locked_reg_bank.sv
// Directed and randomized bench for locked_reg_bank against a cycle-level behavioural model;
// debug-window scenarios are compiled in when LOCKED_REG_BANK_DEBUG_EN is defined.
`timescale 1ns/1ps
module tb_locked_reg_bank;

    localparam int DATA_W      = 16;
    localparam int NUM_REGS    = 3;
    localparam int ADDR_W      = 2;
    localparam int CNT_W       = 8;
    localparam int DBG_TIMEOUT = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic                Clk = 1'b0;
    logic                resetn = 1'b0;
    logic                write = 1'b0;
    logic [ADDR_W-1:0]   wr_addr = '0;
    logic [DATA_W-1:0]   Data_in = '0;
    logic                Lock = 1'b0;
    logic [ADDR_W-1:0]   lock_addr = '0;
    logic                debug_unlocked = 1'b0;
    logic [ADDR_W-1:0]   rd_addr = '0;
    logic [DATA_W-1:0]   Data_out;
    logic [NUM_REGS-1:0] lock_status;
    logic                viol_pulse;
    logic [CNT_W-1:0]    viol_cnt;
    logic                dbg_open;

    int n_cmp = 0;
    int n_err = 0;

    int unsigned m_reg [NUM_REGS];
    bit          m_lock [NUM_REGS];
    int          m_cnt;
    bit          m_pulse;
    int unsigned m_dout;
    int          m_win;
    bit          m_need_low;
    bit          m_prev;

    locked_reg_bank #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .CNT_W(CNT_W), .DBG_TIMEOUT(DBG_TIMEOUT)
    ) dut (
        .Clk(Clk), .resetn(resetn), .write(write), .wr_addr(wr_addr),
        .Data_in(Data_in), .Lock(Lock), .lock_addr(lock_addr),
        .debug_unlocked(debug_unlocked), .rd_addr(rd_addr),
        .Data_out(Data_out), .lock_status(lock_status), .viol_pulse(viol_pulse),
        .viol_cnt(viol_cnt), .dbg_open(dbg_open)
    );

    always #5 Clk = ~Clk;

    function automatic void model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_reg[i]  = 0;
            m_lock[i] = 1'b0;
        end
        m_cnt      = 0;
        m_pulse    = 1'b0;
        m_dout     = 0;
        m_win      = 0;
        m_need_low = 1'b1;
        m_prev     = 1'b0;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void model_edge();
        int wa = int'(wr_addr);
        int la = int'(lock_addr);
        int ra = int'(rd_addr);
        bit open_now = (m_win > 0);
        bit in_range = (wa < NUM_REGS);
        bit locked = in_range ? m_lock[wa] : 1'b0;
        bit accept;
        bit rise;
        accept  = write && in_range && (!locked || open_now) && !(Lock && la == wa);
        m_dout  = (ra < NUM_REGS) ? m_reg[ra] : 0;
        if (accept) m_reg[wa] = int'(Data_in);
        if (Lock && la < NUM_REGS) m_lock[la] = 1'b1;
        m_pulse = write && !accept;
        if (m_pulse && m_cnt < CNT_MAX) m_cnt++;
`ifdef LOCKED_REG_BANK_DEBUG_EN
        rise = debug_unlocked && !m_prev && !m_need_low;
        if (open_now) m_win = debug_unlocked ? m_win - 1 : 0;
        else if (rise) m_win = DBG_TIMEOUT;
        m_prev = debug_unlocked;
        if (!debug_unlocked) m_need_low = 1'b0;
`else
        rise = 1'b0;
        m_win = 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_lock;
        exp_lock = '0;
        for (int i = 0; i < NUM_REGS; i++) exp_lock[i] = m_lock[i];
        chk({tag, ".Data_out"}, 32'(Data_out), m_dout);
        chk({tag, ".lock_status"}, 32'(lock_status), exp_lock);
        chk({tag, ".viol_pulse"}, 32'(viol_pulse), 32'(m_pulse));
        chk({tag, ".viol_cnt"}, 32'(viol_cnt), 32'(m_cnt));
        chk({tag, ".dbg_open"}, 32'(dbg_open), 32'(m_win > 0));
    endtask

    task automatic drive(input bit w, input int wa, input int d, input bit lk, input int la, input int ra);
        write     = w;
        wr_addr   = ADDR_W'(wa);
        Data_in   = DATA_W'(d);
        Lock      = lk;
        lock_addr = ADDR_W'(la);
        rd_addr   = ADDR_W'(ra);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge Clk);
        #1;
        check_all(tag);
    endtask

    // Called 1ns after an edge: asserts reset between edges and releases it before the next one.
    task automatic pulse_reset(input string tag);
        resetn = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        resetn = 1'b1;
        #1;
    endtask

    task automatic random_phase(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
                  ($urandom_range(0, 11) == 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 5) == 0) debug_unlocked = ~debug_unlocked;
            step(tag);
        end
    endtask

    initial begin
        model_reset();
        #3;
        check_all("reset");
        #5 resetn = 1'b1;

        drive(1, 1, 'hA5A5, 0, 0, 1);
        step("wr1");
        drive(0, 0, 0, 0, 0, 1);
        step("rd1");
        chk("rd1.const", 32'(Data_out), 32'hA5A5);
        chk("rd1.cnt0", 32'(viol_cnt), 0);

        drive(0, 0, 0, 1, 1, 1);
        step("lock1");
        drive(1, 1, 'h1234, 0, 0, 1);
        step("wr_locked1");
        chk("wr_locked1.pulse", 32'(viol_pulse), 1);
        chk("wr_locked1.cnt", 32'(viol_cnt), 1);
        drive(0, 0, 0, 0, 0, 1);
        step("after_locked1");
        chk("after_locked1.pulse", 32'(viol_pulse), 0);
        chk("after_locked1.keep", 32'(Data_out), 32'hA5A5);

        drive(1, 2, 'h5555, 1, 2, 2);
        step("wr_lock2");
        chk("wr_lock2.lock", 32'(lock_status[2]), 1);
        chk("wr_lock2.cnt", 32'(viol_cnt), 2);
        drive(0, 0, 0, 0, 0, 2);
        step("rd2");
        chk("rd2.keep", 32'(Data_out), 0);
        drive(1, 3, 'h7777, 0, 0, 3);
        step("wr_oor");
        drive(1, 0, 'h0F0F, 0, 0, 0);
        step("rd_oor_wr0");
        drive(0, 0, 0, 0, 0, 0);
        step("rd0");
        chk("rd0.const", 32'(Data_out), 32'h0F0F);

        random_phase("rand1", 200);

        pulse_reset("rst_sat");
        debug_unlocked = 1'b0;
        for (int k = 0; k < 260; k++) begin
            drive(1, 3, k, 0, 0, 0);
            step("sat");
        end
        chk("sat.cnt", 32'(viol_cnt), 255);
        drive(1, 0, 'h1111, 0, 0, 0);
        step("sat_ok");
        chk("sat_ok.cnt", 32'(viol_cnt), 255);
        chk("sat_ok.pulse", 32'(viol_pulse), 0);

`ifdef LOCKED_REG_BANK_DEBUG_EN
        pulse_reset("rst_dbg");
        debug_unlocked = 1'b0;
        drive(1, 1, 'hAAAA, 0, 0, 1);
        step("dbg_pre_wr");
        drive(0, 0, 0, 1, 1, 1);
        step("dbg_lock");
        debug_unlocked = 1'b1;
        drive(0, 0, 0, 0, 0, 1);
        step("dbg_e0");
        chk("dbg_e0.open", 32'(dbg_open), 1);
        step("dbg_e1");
        drive(1, 1, 'hBEEF, 0, 0, 1);
        step("dbg_e2");
        chk("dbg_e2.pulse", 32'(viol_pulse), 0);
        drive(0, 0, 0, 0, 0, 1);
        step("dbg_e3");
        step("dbg_e4");
        chk("dbg_e4.closed", 32'(dbg_open), 0);
        step("dbg_e5");
        drive(1, 1, 'hC0DE, 0, 0, 1);
        step("dbg_e6");
        chk("dbg_e6.pulse", 32'(viol_pulse), 1);
        drive(0, 0, 0, 0, 0, 1);
        step("dbg_rd");
        chk("dbg_rd.val", 32'(Data_out), 32'hBEEF);
        for (int k = 0; k < 6; k++) step("dbg_held");
        chk("dbg_held.closed", 32'(dbg_open), 0);

        debug_unlocked = 1'b0;
        step("rst_win_low");
        debug_unlocked = 1'b1;
        step("rst_win_open");
        chk("rst_win_open.open", 32'(dbg_open), 1);
        step("rst_win_mid");
        pulse_reset("rst_mid_window");
        chk("rst_mid_window.open", 32'(dbg_open), 0);
        for (int k = 0; k < 4; k++) step("rst_held");
        chk("rst_held.closed", 32'(dbg_open), 0);
        debug_unlocked = 1'b0;
        step("rst_low");
        debug_unlocked = 1'b1;
        step("rst_reopen");
        chk("rst_reopen.open", 32'(dbg_open), 1);
`else
        pulse_reset("rst_nodbg");
        debug_unlocked = 1'b0;
        drive(0, 0, 0, 1, 1, 1);
        step("nodbg_lock");
        debug_unlocked = 1'b1;
        drive(0, 0, 0, 0, 0, 1);
        step("nodbg_rise");
        chk("nodbg_rise.open", 32'(dbg_open), 0);
        drive(1, 1, 'hBEEF, 0, 0, 1);
        step("nodbg_wr");
        chk("nodbg_wr.pulse", 32'(viol_pulse), 1);
        drive(0, 0, 0, 0, 0, 1);
        step("nodbg_rd");
        chk("nodbg_rd.val", 32'(Data_out), 0);
`endif

        pulse_reset("rst_rand2");
        random_phase("rand2", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
